// File: rtl/tm_sch_pri_sel_pkg.sv
// Shared constants for the priority-scheduler queue selector: default widths,
// control-word field offsets and FSM state encoding.
package tm_sch_pri_sel_pkg;

  localparam int SECOND_LVL_QUEUE_ID_NBITS = 6;
  localparam int SECOND_LVL_SCH_ID_NBITS   = 4;

  // Control word layout: {first_q, last_q}
  localparam int CTRL_LAST_Q_LSB = 0;

  function automatic int ctrl_first_q_lsb(input int qid_nbits);
    return qid_nbits;
  endfunction

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SCAN = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

endpackage

// File: rtl/tm_sch_pri_sel_if.sv
// Bus bundle for one selector instance: request in, control-memory read port,
// queue-nonempty probe and the selection result.
interface tm_sch_pri_sel_if
  import tm_sch_pri_sel_pkg::*;
#(
  parameter int QID_NBITS = SECOND_LVL_QUEUE_ID_NBITS,
  parameter int SCH_NBITS = SECOND_LVL_SCH_ID_NBITS
);

  logic                   req_valid;
  logic [SCH_NBITS-1:0]   req_sch_id;
  logic                   req_ready;

  logic                   pri_sch_ctrl_rd;
  logic [SCH_NBITS-1:0]   pri_sch_ctrl_raddr;
  logic                   pri_sch_ctrl_ack;
  logic [2*QID_NBITS-1:0] pri_sch_ctrl_rdata;

  logic [QID_NBITS-1:0]   q_chk_id;
  logic                   q_chk_nonempty;

  logic                   sel_valid;
  logic                   sel_ready;
  logic [SCH_NBITS-1:0]   sel_sch_id;
  logic [QID_NBITS-1:0]   sel_queue_id;
  logic                   sel_found;
  logic                   cfg_err;

  // master: the selector block itself
  modport master (
    input  req_valid, req_sch_id, pri_sch_ctrl_ack, pri_sch_ctrl_rdata,
           q_chk_nonempty, sel_ready,
    output req_ready, pri_sch_ctrl_rd, pri_sch_ctrl_raddr, q_chk_id,
           sel_valid, sel_sch_id, sel_queue_id, sel_found, cfg_err
  );

  // slave: the surrounding scheduler level, memory and queue lookup
  modport slave (
    output req_valid, req_sch_id, pri_sch_ctrl_ack, pri_sch_ctrl_rdata,
           q_chk_nonempty, sel_ready,
    input  req_ready, pri_sch_ctrl_rd, pri_sch_ctrl_raddr, q_chk_id,
           sel_valid, sel_sch_id, sel_queue_id, sel_found, cfg_err
  );

endinterface

// File: rtl/tm_sch_req_fifo.sv
// Generic synchronous FIFO, 2^DEPTH_NBITS entries, show-ahead read data.
module tm_sch_req_fifo #(
  parameter int WIDTH       = 4,
  parameter int DEPTH_NBITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_NBITS;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_NBITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_NBITS:0]   cnt;
  logic                   do_wr, do_rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == (DEPTH_NBITS+1)'(DEPTH));

  // A pop frees the slot being written, so a full FIFO may push and pop together.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tm_sch_pri_sel.sv
// Priority queue selector: fetch a scheduler's {first_q,last_q} range and return
// the lowest-numbered nonempty queue in it, one lookup at a time.
module tm_sch_pri_sel
  import tm_sch_pri_sel_pkg::*;
#(
  parameter int QID_NBITS        = SECOND_LVL_QUEUE_ID_NBITS,
  parameter int SCH_NBITS        = SECOND_LVL_SCH_ID_NBITS,
  parameter int FIFO_DEPTH_NBITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  tm_sch_pri_sel_if.master bus
);

  localparam int CTRL_FIRST_Q_LSB = ctrl_first_q_lsb(QID_NBITS);

  logic [2:0]           state, state_nxt;
  logic [SCH_NBITS-1:0] cur_sch;
  logic [QID_NBITS-1:0] scan_q, last_q;
  logic [QID_NBITS-1:0] ack_first, ack_last;
  logic                 ack_err, wait_ack;
  logic                 in_scan, hit, scan_end, scan_done;
  logic                 sel_fire;

  logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [SCH_NBITS-1:0] fifo_head;

  logic [SCH_NBITS-1:0] sel_sch_q;
  logic [QID_NBITS-1:0] sel_qid_q;
  logic                 sel_found_q;

  assign fifo_push = bus.req_valid & ~fifo_full;

  tm_sch_req_fifo #(
    .WIDTH       (SCH_NBITS),
    .DEPTH_NBITS (FIFO_DEPTH_NBITS)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_push),
    .wr_data (bus.req_sch_id),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign ack_first = bus.pri_sch_ctrl_rdata[CTRL_FIRST_Q_LSB +: QID_NBITS];
  assign ack_last  = bus.pri_sch_ctrl_rdata[CTRL_LAST_Q_LSB +: QID_NBITS];
  assign ack_err   = (ack_first > ack_last);

  // Acks outside WAIT (e.g. a late one after reset) never reach the datapath.
  assign wait_ack  = (state == ST_WAIT) & bus.pri_sch_ctrl_ack;

  assign in_scan   = (state == ST_SCAN);
  assign hit       = in_scan & bus.q_chk_nonempty;
  assign scan_end  = in_scan & (scan_q == last_q);
  assign scan_done = hit | scan_end;

  assign sel_fire  = (state == ST_OUT) & bus.sel_ready;

  // Pop on entry to RD, either from IDLE or directly out of an accepted result.
  assign fifo_pop  = ~fifo_empty & ((state == ST_IDLE) | sel_fire);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_WAIT;
      ST_WAIT: if (bus.pri_sch_ctrl_ack) state_nxt = ack_err ? ST_OUT : ST_SCAN;
      ST_SCAN: if (scan_done) state_nxt = ST_OUT;
      ST_OUT:  if (bus.sel_ready) state_nxt = fifo_empty ? ST_IDLE : ST_RD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cur_sch <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) cur_sch <= fifo_head;
    end
  end

  // scan_q doubles as q_chk_id, so it only moves on ack or a scan miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      last_q <= '0;
    end else if (wait_ack) begin
      last_q <= ack_last;
      if (!ack_err) scan_q <= ack_first;
    end else if (in_scan && !scan_done) begin
      scan_q <= scan_q + 1'b1;
    end
  end

  // Result registers hold while OUT waits on sel_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sch_q   <= '0;
      sel_qid_q   <= '0;
      sel_found_q <= 1'b0;
    end else if (wait_ack && ack_err) begin
      sel_sch_q   <= cur_sch;
      sel_qid_q   <= '0;
      sel_found_q <= 1'b0;
    end else if (scan_done) begin
      sel_sch_q   <= cur_sch;
      sel_qid_q   <= hit ? scan_q : '0;
      sel_found_q <= hit;
    end
  end

  assign bus.req_ready          = ~fifo_full;
  assign bus.pri_sch_ctrl_rd    = (state == ST_RD);
  assign bus.pri_sch_ctrl_raddr = cur_sch;
  assign bus.q_chk_id           = scan_q;
  assign bus.sel_valid          = (state == ST_OUT);
  assign bus.sel_sch_id         = sel_sch_q;
  assign bus.sel_queue_id       = sel_qid_q;
  assign bus.sel_found          = sel_found_q;
  assign bus.cfg_err            = wait_ack & ack_err;

endmodule

// File: tb/tb_tm_sch_pri_sel.sv
// Bench for tm_sch_pri_sel: directed scenarios plus randomized lookups checked
// against a range-scan reference model.
module tb_tm_sch_pri_sel;

  localparam int Q = 6;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tm_sch_pri_sel_if #(.QID_NBITS(Q), .SCH_NBITS(S)) bus();

  tm_sch_pri_sel #(.QID_NBITS(Q), .SCH_NBITS(S), .FIFO_DEPTH_NBITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2*Q-1:0] ctrl_tbl [1<<S];
  logic [63:0]    ne_tbl;
  int             fixed_lat;
  int             rd_cnt, ack_cnt, rd_delta;
  logic [S-1:0]   rd_addr;
  int             n_cmp, n_err;
  int             probe_log[$];
  int             ack_c, cfg_c, sv_c, cfg_n;

  assign bus.q_chk_nonempty = ne_tbl[bus.q_chk_id];

  // Control memory: answers each read after fixed_lat cycles (random when 0).
  initial begin
    int lat;
    bus.pri_sch_ctrl_ack   = 1'b0;
    bus.pri_sch_ctrl_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pri_sch_ctrl_rd === 1'b1) begin
        rd_cnt++;
        rd_addr = bus.pri_sch_ctrl_raddr;
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clk);
        #1;
        bus.pri_sch_ctrl_ack   = 1'b1;
        bus.pri_sch_ctrl_rdata = ctrl_tbl[rd_addr];
        @(posedge clk);
        #1;
        bus.pri_sch_ctrl_ack   = 1'b0;
        bus.pri_sch_ctrl_rdata = (2*Q)'($urandom);
        ack_cnt++;
      end
    end
  end

  // Reference: lowest nonempty queue in [first,last]; first > last is a config error.
  function automatic void ref_sel(input logic [2*Q-1:0] cw, input logic [63:0] ne,
                                  output bit err, output bit found,
                                  output int qid, output int nprobe, output int first);
    int l;
    first = int'(cw[2*Q-1:Q]);
    l     = int'(cw[Q-1:0]);
    err = (first > l); found = 0; qid = 0; nprobe = 0;
    if (!err) begin
      for (int q = first; q <= l; q++) begin
        nprobe++;
        if (ne[q]) begin found = 1; qid = q; break; end
      end
    end
  endfunction

  function automatic bit probes_ok(input int first, input int n);
    if (probe_log.size() != n) return 0;
    foreach (probe_log[i]) if (probe_log[i] != first + i) return 0;
    return 1;
  endfunction

  function automatic logic [24:0] out_vec();
    return {bus.req_ready, bus.pri_sch_ctrl_rd, bus.pri_sch_ctrl_raddr, bus.q_chk_id,
            bus.sel_valid, bus.sel_sch_id, bus.sel_queue_id, bus.sel_found, bus.cfg_err};
  endfunction

  task automatic push_req(input logic [S-1:0] id);
    @(posedge clk); #1;
    bus.req_valid  = 1'b1;
    bus.req_sch_id = id;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
  endtask

  // Waits for sel_valid, logging ack/cfg_err cycles and probes made after the ack.
  task automatic wait_result(input int budget, output bit got);
    bit seen_ack = 0;
    got = 0; probe_log.delete();
    ack_c = -1; cfg_c = -1; sv_c = -1; cfg_n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.cfg_err) begin cfg_c = i; cfg_n++; end
      if (bus.sel_valid) begin sv_c = i; got = 1; break; end
      if (seen_ack) probe_log.push_back(int'(bus.q_chk_id));
      if (bus.pri_sch_ctrl_ack) begin seen_ack = 1; ack_c = i; end
    end
  endtask

  task automatic run_one(input logic [S-1:0] id, input logic [2*Q-1:0] cw,
                         input logic [63:0] ne, input int lat, output bit got);
    int rd0;
    rd0 = rd_cnt;
    ctrl_tbl[id] = cw; ne_tbl = ne; fixed_lat = lat;
    push_req(id);
    wait_result(400, got);
    rd_delta = rd_cnt - rd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_vec() !== 25'h100_0000) begin
      n_err++; $display("FAIL reset_hold: got %h want %h", out_vec(), 25'h100_0000);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_vec() !== 25'h100_0000) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", out_vec(), 25'h100_0000);
    end
  endtask

  task automatic test_single_hit();
    bit got;
    run_one(4'd3, {6'd8, 6'd15}, 64'd1 << 10, 2, got);
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL hit_timeout: got no sel_valid want sel_valid"); end
    n_cmp++;
    if (rd_delta !== 1 || rd_addr !== 4'd3) begin
      n_err++; $display("FAIL hit_rd: got %0d reads addr %0d want 1 read addr 3", rd_delta, rd_addr);
    end
    n_cmp++;
    if (sv_c - ack_c !== 4) begin
      n_err++; $display("FAIL hit_latency: got %0d want 4", sv_c - ack_c);
    end
    n_cmp++;
    if ({bus.sel_sch_id, bus.sel_queue_id, bus.sel_found} !== {4'd3, 6'd10, 1'b1}) begin
      n_err++; $display("FAIL hit_result: got sch %0d q %0d f %0d want sch 3 q 10 f 1",
                        bus.sel_sch_id, bus.sel_queue_id, bus.sel_found);
    end
    n_cmp++;
    if (!probes_ok(8, 3) || cfg_n != 0) begin
      n_err++; $display("FAIL hit_probes: got %0d probes cfg %0d want 3 probes from 8 cfg 0",
                        probe_log.size(), cfg_n);
    end
  endtask

  task automatic test_miss();
    bit got;
    run_one(4'd5, {6'd20, 6'd23}, 64'd0, 0, got);
    n_cmp++;
    if (!got || !probes_ok(20, 4)) begin
      n_err++; $display("FAIL miss_probes: got valid %0d probes %0d want valid 1 probes 20..23",
                        got, probe_log.size());
    end
    n_cmp++;
    if ({bus.sel_sch_id, bus.sel_queue_id, bus.sel_found} !== {4'd5, 6'd0, 1'b0}) begin
      n_err++; $display("FAIL miss_result: got sch %0d q %0d f %0d want sch 5 q 0 f 0",
                        bus.sel_sch_id, bus.sel_queue_id, bus.sel_found);
    end
    n_cmp++;
    if (sv_c - ack_c !== 5) begin
      n_err++; $display("FAIL miss_latency: got %0d want 5", sv_c - ack_c);
    end
  endtask

  task automatic test_cfg_err();
    bit got;
    run_one(4'd9, {6'd9, 6'd5}, 64'hFFFF_FFFF_FFFF_FFFF, 3, got);
    n_cmp++;
    if (cfg_n !== 1 || cfg_c !== ack_c) begin
      n_err++; $display("FAIL cfg_pulse: got %0d pulses at %0d want 1 at %0d", cfg_n, cfg_c, ack_c);
    end
    n_cmp++;
    if (!got || sv_c !== ack_c + 1 || probe_log.size() != 0) begin
      n_err++; $display("FAIL cfg_timing: got sel at %0d scan %0d want sel at %0d scan 0",
                        sv_c, probe_log.size(), ack_c + 1);
    end
    n_cmp++;
    if ({bus.sel_sch_id, bus.sel_queue_id, bus.sel_found} !== {4'd9, 6'd0, 1'b0}) begin
      n_err++; $display("FAIL cfg_result: got sch %0d q %0d f %0d want sch 9 q 0 f 0",
                        bus.sel_sch_id, bus.sel_queue_id, bus.sel_found);
    end
  endtask

  task automatic test_boundary();
    bit got;
    run_one(4'd15, {6'd63, 6'd63}, 64'd1 << 63, 1, got);
    n_cmp++;
    if (!got || !probes_ok(63, 1) || sv_c !== ack_c + 2) begin
      n_err++; $display("FAIL bound_probe: got %0d probes lat %0d want 1 probe lat 2",
                        probe_log.size(), sv_c - ack_c);
    end
    n_cmp++;
    if ({bus.sel_queue_id, bus.sel_found} !== {6'd63, 1'b1}) begin
      n_err++; $display("FAIL bound_result: got q %0d f %0d want q 63 f 1",
                        bus.sel_queue_id, bus.sel_found);
    end
  endtask

  function automatic logic [2*Q-1:0] rand_cw();
    int f, l;
    f = int'($urandom_range(0, 63));
    if (f > 0 && $urandom_range(0, 5) == 0) l = int'($urandom_range(0, f - 1));
    else l = (f + int'($urandom_range(0, 12)) > 63) ? 63 : f + int'($urandom_range(0, 12));
    return {6'(f), 6'(l)};
  endfunction

  function automatic logic [63:0] rand_ne();
    if ($urandom_range(0, 4) == 0) return 64'd0;
    return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
  endfunction

  task automatic test_random();
    bit got, err, fnd;
    int qid, np, f;
    logic [S-1:0] id;
    logic [2*Q-1:0] cw;
    logic [63:0] ne;
    for (int t = 0; t < 25; t++) begin
      id = S'($urandom); cw = rand_cw(); ne = rand_ne();
      ref_sel(cw, ne, err, fnd, qid, np, f);
      run_one(id, cw, ne, 0, got);
      n_cmp++;
      if (!got || bus.sel_sch_id !== id || bus.sel_found !== fnd || int'(bus.sel_queue_id) != qid
          || cfg_n != int'(err) || sv_c != ack_c + 1 + np || !probes_ok(f, np)) begin
        n_err++;
        $display("FAIL rand_%0d: got sch %0d q %0d f %0d cfg %0d lat %0d probes %0d want sch %0d q %0d f %0d cfg %0d lat %0d probes %0d",
                 t, bus.sel_sch_id, bus.sel_queue_id, bus.sel_found, cfg_n, sv_c - ack_c,
                 probe_log.size(), id, qid, fnd, err, 1 + np, np);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit err, fnd, acc_ok, stable, got;
    int qid, np, f, idx;
    int exp_q[5]; bit exp_f[5];
    logic [10:0] snap;
    ne_tbl = rand_ne(); fixed_lat = 0;
    for (int i = 1; i <= 5; i++) begin
      ctrl_tbl[i] = rand_cw();
      ref_sel(ctrl_tbl[i], ne_tbl, err, fnd, qid, np, f);
      exp_q[i-1] = qid; exp_f[i-1] = fnd;
    end
    @(posedge clk); #1;
    bus.sel_ready = 1'b0;
    acc_ok = 1;
    for (int i = 1; i <= 5; i++) begin
      bus.req_valid = 1'b1; bus.req_sch_id = S'(i);
      @(negedge clk);
      if (!bus.req_ready) acc_ok = 0;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    n_cmp++;
    if (!acc_ok) begin n_err++; $display("FAIL b2b_accept: got a stalled push want 5 accepted"); end
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_full: got req_ready %0d want 0", bus.req_ready);
    end
    wait_result(200, got);
    snap = {bus.sel_sch_id, bus.sel_queue_id, bus.sel_found};
    stable = got;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.sel_valid || {bus.sel_sch_id, bus.sel_queue_id, bus.sel_found} !== snap
          || bus.req_ready) stable = 0;
    end
    n_cmp++;
    if (!stable || snap !== {4'd1, 6'(exp_q[0]), exp_f[0]}) begin
      n_err++; $display("FAIL b2b_hold: got %h stable %0d want %h stable 1",
                        snap, stable, {4'd1, 6'(exp_q[0]), exp_f[0]});
    end
    @(posedge clk); #1;
    bus.sel_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 600 && idx < 5; c++) begin
      @(negedge clk);
      if (bus.sel_valid) begin
        n_cmp++;
        if ({bus.sel_sch_id, bus.sel_queue_id, bus.sel_found} !== {4'(idx + 1), 6'(exp_q[idx]), exp_f[idx]}) begin
          n_err++; $display("FAIL b2b_drain_%0d: got sch %0d q %0d f %0d want sch %0d q %0d f %0d",
                            idx, bus.sel_sch_id, bus.sel_queue_id, bus.sel_found,
                            idx + 1, exp_q[idx], exp_f[idx]);
        end
        idx++;
      end
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (idx != 5 || bus.req_ready !== 1'b1 || bus.sel_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_done: got %0d results ready %0d valid %0d want 5 ready 1 valid 0",
                        idx, bus.req_ready, bus.sel_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    int rd0, ack0, c;
    bit bad;
    ctrl_tbl[7] = {6'd2, 6'd4}; ne_tbl = 64'd1 << 3; fixed_lat = 6;
    rd0 = rd_cnt; ack0 = ack_cnt;
    push_req(4'd7);
    c = 0;
    while (rd_cnt == rd0 && c < 50) begin @(negedge clk); c++; end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_vec() !== 25'h100_0000) begin
      n_err++; $display("FAIL rstw_hold: got %h want %h", out_vec(), 25'h100_0000);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_vec() !== 25'h100_0000) bad = 1;
    end
    n_cmp++;
    if (bad || rd_cnt != rd0 + 1 || ack_cnt != ack0 + 1) begin
      n_err++; $display("FAIL rstw_late_ack: got outputs %h reads %0d acks %0d want %h 1 read 1 ignored ack",
                        out_vec(), rd_cnt - rd0, ack_cnt - ack0, 25'h100_0000);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_sch_id = '0;
    bus.sel_ready = 1'b1;
    ne_tbl = '0;
    fixed_lat = 0;
    for (int i = 0; i < (1 << S); i++) ctrl_tbl[i] = {6'(i), 6'(i + 4)};
    test_reset();
    test_single_hit();
    test_miss();
    test_cfg_err();
    test_boundary();
    test_random();
    test_back_to_back();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
